// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word and register widths, flag bit positions and
// the commit-buffer entry layout used by the writeback stage.
package cpu_pkg;

    localparam int WORD_W = 16;
    localparam int REG_AW = 3;
    localparam int NZCV_W = 4;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic [WORD_W-1:0] res;
        logic [NZCV_W-1:0] nzcv;
        logic [REG_AW-1:0] rd;
        logic              we;
        logic              fwe;
    } wb_entry_t;

    localparam int ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/wb_fifo.sv
// Circular commit buffer: storage, read/write pointers and occupancy count.
// The raw storage is exported so the writeback stage can scan pending entries.
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 8,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic [W-1:0]            din_i,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [PW:0]             count_o,
    output logic [PW-1:0]           rd_ptr_o,
    output logic [DEPTH-1:0][W-1:0] mem_o
);

    logic [DEPTH-1:0][W-1:0] mem_q;
    logic [PW-1:0]           wr_ptr_q;
    logic [PW-1:0]           rd_ptr_q;
    logic [PW:0]             count_q;
    logic                    push_ok;
    logic                    pop_ok;

    assign full_o   = (count_q == (PW+1)'(DEPTH));
    assign empty_o  = (count_q == '0);
    assign push_ok  = push_i && !full_o;
    assign pop_ok   = pop_i && !empty_o;
    assign count_o  = count_q;
    assign rd_ptr_o = rd_ptr_q;
    assign mem_o    = mem_q;

    // DEPTH is a power of two, so pointers wrap by plain overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: buffers ALU results and commits them in order to the
// register file and flags. Define WB_BYPASS_EN to forward pending results.
module alu_writeback
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int NREGS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_res,
    input  logic [NZCV_W-1:0] in_nzcv,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_we,
    input  logic              in_fwe,
    input  logic              wb_hold,
    input  logic [REG_AW-1:0] ra_addr,
    input  logic [REG_AW-1:0] rb_addr,
    output logic [WORD_W-1:0] ra_data,
    output logic [WORD_W-1:0] rb_data,
    output logic              hazard_a,
    output logic              hazard_b,
    output logic [NZCV_W-1:0] flags,
    output logic [15:0]       commit_cnt
);

    localparam int PW = $clog2(DEPTH);

    wb_entry_t                     in_ent;
    wb_entry_t                     head;
    wb_entry_t [DEPTH-1:0]         pend;
    logic      [DEPTH-1:0]         live;
    logic      [DEPTH-1:0][ENTRY_W-1:0] mem_w;
    logic      [PW-1:0]            rd_ptr_w;
    logic      [PW:0]              count_w;
    logic                          full;
    logic                          empty;
    logic                          push;
    logic                          pop;

    logic [WORD_W-1:0] regs_q [NREGS];
    logic [NZCV_W-1:0] flags_q;
    logic [15:0]       commit_cnt_q;

    assign in_ent = '{res: in_res, nzcv: in_nzcv, rd: in_rd, we: in_we, fwe: in_fwe};
    assign push     = in_valid && !full;
    assign pop      = !empty && !wb_hold;
    assign in_ready = !full;

    wb_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_i   (push),
        .pop_i    (pop),
        .din_i    (in_ent),
        .full_o   (full),
        .empty_o  (empty),
        .count_o  (count_w),
        .rd_ptr_o (rd_ptr_w),
        .mem_o    (mem_w)
    );

    // pend[0] is the oldest entry, pend[count-1] the youngest
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            pend[k] = mem_w[rd_ptr_w + PW'(k)];
            live[k] = ((PW+1)'(k) < count_w);
        end
    end

    assign head = pend[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            flags_q      <= '0;
            commit_cnt_q <= '0;
        end else if (pop) begin
            if (head.we && (head.rd != '0)) begin
                regs_q[head.rd] <= head.res;
            end
            if (head.fwe) begin
                flags_q[FLAG_N] <= head.nzcv[FLAG_N];
                flags_q[FLAG_Z] <= head.nzcv[FLAG_Z];
                flags_q[FLAG_C] <= head.nzcv[FLAG_C];
                flags_q[FLAG_V] <= head.nzcv[FLAG_V];
            end
            commit_cnt_q <= commit_cnt_q + 16'd1;
        end
    end

    assign flags      = flags_q;
    assign commit_cnt = commit_cnt_q;

    logic              a_hit, b_hit;
    logic [WORD_W-1:0] a_fwd, b_fwd;
    logic [WORD_W-1:0] a_arch, b_arch;

    // Scan oldest to youngest so the youngest matching write wins
    always_comb begin
        a_hit = 1'b0;
        b_hit = 1'b0;
        a_fwd = '0;
        b_fwd = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (live[k] && pend[k].we && (pend[k].rd == ra_addr)) begin
                a_hit = 1'b1;
                a_fwd = pend[k].res;
            end
            if (live[k] && pend[k].we && (pend[k].rd == rb_addr)) begin
                b_hit = 1'b1;
                b_fwd = pend[k].res;
            end
        end
    end

    assign a_arch = (ra_addr == '0) ? '0 : regs_q[ra_addr];
    assign b_arch = (rb_addr == '0) ? '0 : regs_q[rb_addr];

    logic unused_pend;
    assign unused_pend = ^pend;

`ifdef WB_BYPASS_EN
    assign ra_data  = (a_hit && (ra_addr != '0)) ? a_fwd : a_arch;
    assign rb_data  = (b_hit && (rb_addr != '0)) ? b_fwd : b_arch;
    assign hazard_a = 1'b0;
    assign hazard_b = 1'b0;
`else
    logic unused_fwd;
    assign unused_fwd = ^{a_fwd, b_fwd};
    assign ra_data  = a_arch;
    assign rb_data  = b_arch;
    assign hazard_a = a_hit && (ra_addr != '0);
    assign hazard_b = b_hit && (rb_addr != '0);
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: directed scenarios then random
// traffic, compared every cycle against a queue-based reference model.
module tb_alu_writeback;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_res = '0;
    logic [3:0]  in_nzcv = '0;
    logic [2:0]  in_rd = '0;
    logic        in_we = 1'b0;
    logic        in_fwe = 1'b0;
    logic        wb_hold = 1'b0;
    logic [2:0]  ra_addr = '0;
    logic [2:0]  rb_addr = '0;
    logic [15:0] ra_data, rb_data;
    logic        hazard_a, hazard_b;
    logic [3:0]  flags;
    logic [15:0] commit_cnt;

    always #5 clk = ~clk;

    alu_writeback #(.DEPTH(DEPTH), .NREGS(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_res     (in_res),
        .in_nzcv    (in_nzcv),
        .in_rd      (in_rd),
        .in_we      (in_we),
        .in_fwe     (in_fwe),
        .wb_hold    (wb_hold),
        .ra_addr    (ra_addr),
        .rb_addr    (rb_addr),
        .ra_data    (ra_data),
        .rb_data    (rb_data),
        .hazard_a   (hazard_a),
        .hazard_b   (hazard_b),
        .flags      (flags),
        .commit_cnt (commit_cnt)
    );

    typedef struct {
        logic [15:0] res;
        logic [3:0]  nzcv;
        logic [2:0]  rd;
        logic        we;
        logic        fwe;
    } ent_t;

    ent_t        q[$];
    logic [15:0] m_regs [8];
    logic [3:0]  m_flags;
    logic [15:0] m_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_flags = '0;
        m_cnt   = '0;
    endtask

    function automatic logic [15:0] m_read(input logic [2:0] a);
        logic [15:0] v;
        if (a == 0) return 16'h0000;
        v = m_regs[a];
`ifdef WB_BYPASS_EN
        foreach (q[i]) if (q[i].we && q[i].rd == a) v = q[i].res;
`endif
        return v;
    endfunction

    function automatic logic m_haz(input logic [2:0] a);
        logic h = 1'b0;
`ifndef WB_BYPASS_EN
        if (a != 0) foreach (q[i]) if (q[i].we && q[i].rd == a) h = 1'b1;
`endif
        return h;
    endfunction

    // Reference behaviour at one rising edge, using the inputs presented before it
    task automatic model_edge();
        ent_t e;
        bit   do_pop, do_push;
        if (!rst_n) return;
        do_pop  = (q.size() > 0) && !wb_hold;
        do_push = in_valid && (q.size() < DEPTH);
        if (do_pop) begin
            e = q.pop_front();
            if (e.we && e.rd != 0) m_regs[e.rd] = e.res;
            if (e.fwe) m_flags = e.nzcv;
            m_cnt = m_cnt + 16'd1;
        end
        if (do_push) begin
            e.res = in_res; e.nzcv = in_nzcv; e.rd = in_rd; e.we = in_we; e.fwe = in_fwe;
            q.push_back(e);
        end
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ".in_ready"},   16'(in_ready),   16'(q.size() < DEPTH));
        chk({ctx, ".flags"},      16'(flags),      16'(m_flags));
        chk({ctx, ".commit_cnt"}, commit_cnt,      m_cnt);
        chk({ctx, ".ra_data"},    ra_data,         m_read(ra_addr));
        chk({ctx, ".rb_data"},    rb_data,         m_read(rb_addr));
        chk({ctx, ".hazard_a"},   16'(hazard_a),   16'(m_haz(ra_addr)));
        chk({ctx, ".hazard_b"},   16'(hazard_b),   16'(m_haz(rb_addr)));
    endtask

    task automatic cycle(input string ctx);
        @(posedge clk);
        model_edge();
        #1;
        check_all(ctx);
    endtask

    task automatic drive(input logic v, input logic [15:0] res, input logic [3:0] nzcv,
                         input logic [2:0] rd, input logic we, input logic fwe);
        in_valid = v; in_res = res; in_nzcv = nzcv; in_rd = rd; in_we = we; in_fwe = fwe;
    endtask

    initial begin
        // Reset state
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all("reset");
        chk("reset.in_ready", 16'(in_ready), 16'h0001);
        @(negedge clk) rst_n = 1'b1;

        // First commit: latency and register/flag/count update
        drive(1'b1, 16'h1234, 4'b0000, 3'd3, 1'b1, 1'b1);
        ra_addr = 3'd3;
        cycle("push1");
        drive(1'b0, 16'h0, 4'h0, 3'd0, 1'b0, 1'b0);
        cycle("commit1");
        chk("first.ra", ra_data, 16'h1234);
        chk("first.flags", 16'(flags), 16'h0000);
        chk("first.cnt", commit_cnt, 16'd1);

        // Fill while held, third offer refused, then in-order drain
        wb_hold = 1'b1;
        ra_addr = 3'd1; rb_addr = 3'd2;
        drive(1'b1, 16'h1111, 4'b1000, 3'd1, 1'b1, 1'b0);
        cycle("hold.p1");
        drive(1'b1, 16'h2222, 4'b0001, 3'd2, 1'b1, 1'b0);
        cycle("hold.p2");
        chk("hold.full", 16'(in_ready), 16'h0000);
        drive(1'b1, 16'h0BAD, 4'b1111, 3'd4, 1'b1, 1'b1);
        cycle("hold.p3");
        chk("hold.still_full", 16'(in_ready), 16'h0000);
        wb_hold = 1'b0;
        drive(1'b0, 16'h0, 4'h0, 3'd0, 1'b0, 1'b0);
        cycle("drain1");
        chk("drain1.r1", ra_data, 16'h1111);
        chk("drain1.ready", 16'(in_ready), 16'h0001);
        cycle("drain2");
        chk("drain2.r2", rb_data, 16'h2222);
        chk("drain2.cnt", commit_cnt, 16'd3);

        // Writes to register 0 are discarded but still counted
        ra_addr = 3'd0;
        drive(1'b1, 16'hFFFF, 4'b0000, 3'd0, 1'b1, 1'b0);
        cycle("r0.push");
        drive(1'b0, 16'h0, 4'h0, 3'd0, 1'b0, 1'b0);
        cycle("r0.commit");
        chk("r0.read", ra_data, 16'h0000);
        chk("r0.cnt", commit_cnt, 16'd4);

        // Two pending writes to the same register: forward youngest or flag hazard
        wb_hold = 1'b1;
        rb_addr = 3'd5;
        drive(1'b1, 16'hAAAA, 4'b0000, 3'd5, 1'b1, 1'b0);
        cycle("byp.p1");
        drive(1'b1, 16'h5555, 4'b0000, 3'd5, 1'b1, 1'b0);
        cycle("byp.p2");
`ifdef WB_BYPASS_EN
        chk("byp.rb", rb_data, 16'h5555);
        chk("byp.haz", 16'(hazard_b), 16'h0000);
`else
        chk("byp.rb", rb_data, 16'h0000);
        chk("byp.haz", 16'(hazard_b), 16'h0001);
`endif
        wb_hold = 1'b0;
        drive(1'b0, 16'h0, 4'h0, 3'd0, 1'b0, 1'b0);
        cycle("byp.d1");
        cycle("byp.d2");
        chk("byp.final", rb_data, 16'h5555);

        // Flags only load when fwe is set
        drive(1'b1, 16'h0, 4'b0100, 3'd0, 1'b0, 1'b1);
        cycle("flg.p1");
        drive(1'b1, 16'h0, 4'b1111, 3'd0, 1'b0, 1'b0);
        cycle("flg.p2");
        drive(1'b0, 16'h0, 4'h0, 3'd0, 1'b0, 1'b0);
        cycle("flg.d1");
        cycle("flg.d2");
        chk("flg.keep", 16'(flags), 16'h0004);

        // Reset while full: pending entries are discarded
        wb_hold = 1'b1;
        drive(1'b1, 16'hBEEF, 4'b1010, 3'd6, 1'b1, 1'b1);
        cycle("rst.p1");
        drive(1'b1, 16'hCAFE, 4'b0110, 3'd7, 1'b1, 1'b1);
        cycle("rst.p2");
        chk("rst.full", 16'(in_ready), 16'h0000);
        rst_n = 1'b0;
        model_reset();
        #1 check_all("rst.low");
        chk("rst.ready", 16'(in_ready), 16'h0001);
        chk("rst.flags", 16'(flags), 16'h0000);
        @(negedge clk) rst_n = 1'b1;
        wb_hold = 1'b0;
        drive(1'b0, 16'h0, 4'h0, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            ra_addr = 3'(i);
            rb_addr = 3'(7 - i);
            cycle("rst.sweep");
            chk("rst.reg", ra_data, 16'h0000);
        end
        chk("rst.cnt", commit_cnt, 16'd0);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 1)), 16'($urandom), 4'($urandom), 3'($urandom),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
            wb_hold = ($urandom_range(0, 2) == 0);
            ra_addr = 3'($urandom);
            rb_addr = 3'($urandom);
            cycle("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
